// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execute stage with one-entry output register; ALU_EXEC_MUL_EN adds an iterative shift-add multiply on code 100
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      cs_alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            alu_zero,
    output logic            alu_illegal
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_nxt;
    logic accept, legal, is_mul, mul_last;
    logic [XLEN-1:0] sc_res, mul_res;
    assign accept = in_valid & in_ready;
    assign legal = cs_alu_ctrl inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    always_comb begin
        sc_res = cs_alu_ctrl == 3'b000 ? src_a + src_b :
                 cs_alu_ctrl == 3'b001 ? src_a - src_b :
                 cs_alu_ctrl == 3'b010 ? src_a & src_b :
                 cs_alu_ctrl == 3'b011 ? src_a | src_b :
                 cs_alu_ctrl == 3'b101 ? {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)} :
                 '0;
    end
`ifdef ALU_EXEC_MUL_EN
    localparam int CW = $clog2(XLEN + 1);
    logic [XLEN-1:0] mcand, mplr, acc, acc_nxt;
    logic [CW-1:0] cnt;
    assign is_mul = cs_alu_ctrl == 3'b100;
    assign acc_nxt = acc + (mplr[0] ? mcand : '0);
    assign mul_last = state == BUSY && cnt == CW'(1);
    assign mul_res = acc_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (accept && is_mul) begin
            mcand <= src_a;
            mplr <= src_b;
            acc <= '0;
            cnt <= CW'(XLEN);
        end else if (state == BUSY) begin
            acc <= acc_nxt;
            mcand <= mcand << 1;
            mplr <= mplr >> 1;
            cnt <= cnt - CW'(1);
        end
    end
`else
    assign is_mul = 1'b0;
    assign mul_last = 1'b0;
    assign mul_res = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? (is_mul ? BUSY : DONE) :
                    mul_last ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
    end
    always_comb begin
        in_ready = state == IDLE || (state == DONE && out_ready);
        out_valid = state == DONE;
    end
    // Result is only rewritten on an accept or multiply completion, both impossible while a result is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            alu_zero <= 1'b0;
            alu_illegal <= 1'b0;
        end else if (accept && !is_mul) begin
            alu_result <= sc_res;
            alu_zero <= sc_res == '0;
            alu_illegal <= !legal;
        end else if (mul_last) begin
            alu_result <= mul_res;
            alu_zero <= mul_res == '0;
            alu_illegal <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench with randomized stimulus against a behavioural ALU model
module tb_alu_exec_unit;
    localparam int XLEN = 32;
`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, alu_zero, alu_illegal;
    logic [2:0] cs_alu_ctrl = '0;
    logic [XLEN-1:0] src_a = '0, src_b = '0, alu_result;
    typedef struct {
        logic [XLEN-1:0] res;
        logic ill;
        longint due;
    } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0;
    longint cyc = 0;
    bit seen = 1'b0, rand_rdy = 1'b0;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cs_alu_ctrl(cs_alu_ctrl), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_illegal(alu_illegal)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = $urandom_range(3) != 0;
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        e.ill = 1'b0;
        e.due = 0;
        case (op)
            3'd0: e.res = a + b;
            3'd1: e.res = a - b;
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd5: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd4: begin
                e.res = MUL_EN ? XLEN'(64'(a) * 64'(b)) : '0;
                e.ill = !MUL_EN;
            end
            default: begin
                e.res = '0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        exp_t e;
        bit ok = 1'b0;
        in_valid = 1'b1;
        cs_alu_ctrl = op;
        src_a = a;
        src_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e = model(op, a, b);
                e.due = cyc + 1 + ((MUL_EN && op == 3'd4) ? XLEN : 0);
                sb.push_back(e);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", alu_result, 0);
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) seen = 1'b0;
        else if (out_valid) begin
            if (sb.size() == 0) chk("unexpected_out_valid", out_valid, 0);
            else begin
                if (!seen) begin
                    chk("latency", cyc, sb[0].due);
                    seen = 1'b1;
                end
                chk("result", alu_result, sb[0].res);
                chk("zero", alu_zero, sb[0].res == '0);
                chk("illegal", alu_illegal, sb[0].ill);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        logic [2:0] op;
        logic [XLEN-1:0] a, b;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", alu_result, 0);
        chk("reset_zero", alu_zero, 0);
        chk("reset_illegal", alu_illegal, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'd0, 32'hFFFF_FFFF, 32'h1);
        issue(3'd1, 32'd5, 32'd7);
        issue(3'd5, 32'hFFFF_FFFF, 32'h1);
        drain();
        out_ready = 1'b0;
        issue(3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'd3, 32'h1, 32'h2);
        drain();
        issue(3'd7, $urandom, $urandom);
        issue(3'd6, $urandom, $urandom);
        drain();
        issue(3'd4, 32'h0000_FFFF, 32'h0001_0001);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("mul_in_ready_low", n, MUL_EN ? XLEN : 0);
        @(posedge clk);
        #1;
        drain();
        out_ready = 1'b0;
        issue(3'd0, 32'h1, 32'h2);
        async_reset();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(3'd4, $urandom, $urandom);
        repeat (9) @(negedge clk);
        async_reset();
        n = 0;
        repeat (40) begin
            @(negedge clk);
            n += int'(out_valid);
        end
        chk("no_out_after_reset", n, 0);
        @(posedge clk);
        #1;
        issue(3'd4, 32'd3, 32'd4);
        drain();
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(7));
            a = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom_range(7) == 0) ? a : $urandom;
            issue(op, a, b);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
